// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: FSM states,
// stall-vector patterns and the opcodes that read rt as a source.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        REDIRECT  = 2'd2,
        MEM_WAIT  = 2'd3
    } state_t;

    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_LU    = 6'b001111;
    localparam logic [5:0] STALL_REDIR = 6'b001000;
    localparam logic [5:0] STALL_MEM   = 6'b011111;
    localparam logic [5:0] STALL_ALL   = 6'b111111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Writeback-source code for loads; must match the project defines value.
    localparam logic [1:0] RW_MEM = 2'd1;

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use comparator: flags when the load in MEM writes a register that the
// instruction in EX reads.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] ex_op,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rw,
    input  logic [1:0] mem_rw_src,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (mem_rw == ex_rs);
    // For I-type ALU ops rt is the destination, so it never creates a dependency.
    assign rt_hit = uses_rt(ex_op) && (mem_rw == ex_rt);
    assign lu     = (mem_rw_src == RW_MEM) && (mem_rw != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch
// redirect flush, data-memory wait with watchdog, plus saturating counters.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RUN       | normal issue; hazards evaluated here
// LU_BUBBLE | one cycle after a load-use stall while the bubble drains
// REDIRECT  | one cycle after a flush; behaves like RUN
// MEM_WAIT  | data memory busy; front of pipe frozen, watchdog counting
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ex_op_i,
    input  logic [4:0]       ex_rs_i,
    input  logic [4:0]       ex_rt_i,
    input  logic [4:0]       mem_rw_i,
    input  logic [1:0]       mem_rw_src_i,
    input  logic             pc_redirect_i,
    input  logic             mem_busy_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            nxt;
    logic              pend_redir;
    logic              wd_block;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;
    logic              busy_eff;
    logic              redir;
    logic [5:0]        stall;
    logic              flush;
    logic              pend_set;
    logic              pend_clr;
    logic              wait_inc;
    logic              wait_clr;
    logic              err_set;
    logic              block_set;

    pipe_hazard_det u_hazard (
        .ex_op      (ex_op_i),
        .ex_rs      (ex_rs_i),
        .ex_rt      (ex_rt_i),
        .mem_rw     (mem_rw_i),
        .mem_rw_src (mem_rw_src_i),
        .lu         (lu)
    );

    // After a watchdog abort, a still-asserted busy is ignored until it drops.
    assign busy_eff = mem_busy_i && !wd_block;
    assign redir    = pc_redirect_i || pend_redir;

    always_comb begin
        nxt       = state;
        stall     = STALL_NONE;
        flush     = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        err_set   = 1'b0;
        block_set = 1'b0;
        case (state)
            RUN, REDIRECT: begin
                if (busy_eff) begin
                    stall    = STALL_MEM;
                    nxt      = MEM_WAIT;
                    pend_set = pc_redirect_i;
                end else if (redir) begin
                    stall    = STALL_REDIR;
                    flush    = 1'b1;
                    nxt      = REDIRECT;
                    pend_clr = 1'b1;
                end else if (lu) begin
                    stall = STALL_LU;
                    nxt   = LU_BUBBLE;
                end else begin
                    nxt = RUN;
                end
            end
            LU_BUBBLE: begin
                if (busy_eff) begin
                    stall    = STALL_MEM;
                    nxt      = MEM_WAIT;
                    pend_set = pc_redirect_i;
                end else begin
                    nxt      = RUN;
                    pend_set = pc_redirect_i;
                end
            end
            MEM_WAIT: begin
                pend_set = pc_redirect_i;
                if (!mem_busy_i) begin
                    wait_clr = 1'b1;
                    nxt      = RUN;
                end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                    stall     = STALL_MEM;
                    err_set   = 1'b1;
                    wait_clr  = 1'b1;
                    block_set = 1'b1;
                    nxt       = RUN;
                end else begin
                    stall    = STALL_MEM;
                    wait_inc = 1'b1;
                end
            end
            default: nxt = RUN;
        endcase
    end

    assign stall_o = rst ? STALL_ALL : stall;
    assign flush_o = rst | flush;
    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pend_redir  <= 1'b0;
            wd_block    <= 1'b0;
            wait_cnt    <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            state <= nxt;
            if (pend_clr)
                pend_redir <= 1'b0;
            else if (pend_set)
                pend_redir <= 1'b1;
            if (!mem_busy_i)
                wd_block <= 1'b0;
            else if (block_set)
                wd_block <= 1'b1;
            if (wait_clr)
                wait_cnt <= '0;
            else if (wait_inc)
                wait_cnt <= wait_cnt + 1'b1;
            if (err_set)
                err_o <= 1'b1;
            if ((stall != STALL_NONE) && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule
